stack_burst_sequencer: RTL and testbench

//  Parametrised PUSH/POP multi-register sequencer for the CPU datapath; owns the stack pointer.

---
 rtl/stack_pkg.sv | 20 ++
 rtl/stack_list_scan.sv | 40 ++++
 rtl/stack_burst_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_stack_burst_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types and constants for the stack burst sequencer.
//   state_e        : sequencer FSM states
//   OpPush / OpPop : encodings of the op_push input
//   SpTopDefault   : default empty-stack SP (highest legal SP)
//   SpLimitDefault : default full-stack SP (lowest legal SP)
package stack_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StDone
  } state_e;

  localparam logic OpPop  = 1'b0;
  localparam logic OpPush = 1'b1;

  localparam logic [15:0] SpTopDefault   = 16'hFFFC;
  localparam logic [15:0] SpLimitDefault = 16'h8000;

endpackage

// File: rtl/stack_list_scan.sv
// Combinational register-list scanner.
//   vec_i        : list bits (bit i = entry i)
//   from_idx_i   : search origin
//   from_any_i   : 1 = search from bit 0 inclusive, 0 = only bits strictly above from_idx_i
//   count_o      : number of set bits in vec_i
//   next_idx_o   : lowest qualifying set bit
//   next_valid_o : a qualifying set bit exists
module stack_list_scan #(
  parameter int unsigned NBITS = 9,
  parameter int unsigned IW    = $clog2(NBITS),
  parameter int unsigned CW    = $clog2(NBITS + 1)
) (
  input  logic [NBITS-1:0] vec_i,
  input  logic [IW-1:0]    from_idx_i,
  input  logic             from_any_i,
  output logic [CW-1:0]    count_o,
  output logic [IW-1:0]    next_idx_o,
  output logic             next_valid_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < int'(NBITS); i++) begin
      count_o = count_o + CW'(vec_i[i]);
    end
  end

  // Walk downwards so the lowest qualifying bit is the last one written.
  always_comb begin
    next_idx_o   = '0;
    next_valid_o = 1'b0;
    for (int i = int'(NBITS) - 1; i >= 0; i--) begin
      if (vec_i[i] && (from_any_i || (IW'(i) > from_idx_i))) begin
        next_idx_o   = IW'(i);
        next_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stack_burst_sequencer.sv
// PUSH/POP multi-register sequencer; owns the stack pointer (full-descending stack).
// Walks the sampled register list one DMEM beat per word, lowest RF index at the lowest
// address, with the LR (push) / PC (pop) beat last at the highest address.
//   clk, resetn       : clock, asynchronous active-low reset
//   start, op_push    : op request (sampled in IDLE only), 1 = PUSH
//   reg_list, extra   : register list, extra = LR on push / PC on pop
//   sp_load(_val)     : IDLE-only SP overwrite; dropped if start is also high
//   mem_req/we/addr   : DMEM beat request, held until mem_ack
//   mem_ack           : beat complete (read data valid)
//   rf_addr, lr_sel   : store source / load destination of current beat
//   rf_wr, pc_wr      : load write strobes, qualified by mem_ack
//   busy, done, fault : XFER indicator, completion pulse, stack-limit fault pulse
//   sp_out            : current SP
module stack_burst_sequencer
  import stack_pkg::*;
#(
  parameter int unsigned   NREG     = 8,
  parameter int unsigned   AW       = 16,
  parameter int unsigned   WB       = 4,
  parameter logic [AW-1:0] SP_TOP   = AW'(SpTopDefault),
  parameter logic [AW-1:0] SP_LIMIT = AW'(SpLimitDefault),
  localparam int unsigned  RW       = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            op_push,
  input  logic [NREG-1:0] reg_list,
  input  logic            extra,
  input  logic            sp_load,
  input  logic [AW-1:0]   sp_load_val,
  input  logic            mem_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [RW-1:0]   rf_addr,
  output logic            lr_sel,
  output logic            rf_wr,
  output logic            pc_wr,
  output logic            busy,
  output logic            done,
  output logic            fault,
  output logic [AW-1:0]   sp_out
);

  // The extra (LR/PC) entry sits at bit NREG so it naturally scans last.
  localparam int unsigned NB = NREG + 1;
  localparam int unsigned IW = $clog2(NB);
  localparam int unsigned CW = $clog2(NB + 1);
  localparam int unsigned WS = $clog2(WB);

  state_e        state_q, state_d;
  logic [AW-1:0] sp_q, sp_d;
  logic [AW-1:0] new_sp_q, new_sp_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [NB-1:0] list_q, list_d;
  logic [IW-1:0] cur_q, cur_d;
  logic          op_q, op_d;
  logic          fault_q, fault_d;
  logic          gap_q, gap_d;

  logic [NB-1:0] in_list;
  logic [NB-1:0] scan_vec;
  logic          scan_from_any;
  logic [CW-1:0] scan_count;
  logic [IW-1:0] scan_idx;
  logic          scan_valid;
  logic [AW:0]   off;
  logic [AW:0]   push_diff;
  logic [AW:0]   pop_sum;
  logic          push_fault;
  logic          pop_fault;
  logic          is_extra;

  assign in_list = {extra, reg_list};

  // One scanner serves both phases: in IDLE it counts/finds the first entry of the
  // incoming list, in XFER it finds the entry after the current beat.
  assign scan_vec      = (state_q == StIdle) ? in_list : list_q;
  assign scan_from_any = (state_q == StIdle);

  stack_list_scan #(
    .NBITS (NB),
    .IW    (IW),
    .CW    (CW)
  ) u_scan (
    .vec_i        (scan_vec),
    .from_idx_i   (cur_q),
    .from_any_i   (scan_from_any),
    .count_o      (scan_count),
    .next_idx_o   (scan_idx),
    .next_valid_o (scan_valid)
  );

  // Offset and limit checks carry one extra bit so wrap-around counts as a fault.
  assign off        = (AW + 1)'(scan_count) << WS;
  assign push_diff  = {1'b0, sp_q} - off;
  assign pop_sum    = {1'b0, sp_q} + off;
  assign push_fault = push_diff[AW] || (push_diff[AW-1:0] < SP_LIMIT);
  assign pop_fault  = pop_sum > {1'b0, SP_TOP};

  assign is_extra = (cur_q == IW'(NREG));

  always_comb begin
    state_d  = state_q;
    sp_d     = sp_q;
    new_sp_d = new_sp_q;
    addr_d   = addr_q;
    list_d   = list_q;
    cur_d    = cur_q;
    op_d     = op_q;
    fault_d  = fault_q;
    gap_d    = gap_q;

    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    rf_addr  = '0;
    lr_sel   = 1'b0;
    rf_wr    = 1'b0;
    pc_wr    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    fault    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d     = op_push;
          list_d   = in_list;
          fault_d  = (op_push == OpPush) ? push_fault : pop_fault;
          new_sp_d = (op_push == OpPush) ? push_diff[AW-1:0] : pop_sum[AW-1:0];
          addr_d   = (op_push == OpPush) ? push_diff[AW-1:0] : sp_q;
          cur_d    = scan_idx;
          gap_d    = 1'b0;
          state_d  = (fault_d || !scan_valid) ? StDone : StXfer;
        end else if (sp_load) begin
          sp_d = sp_load_val;
        end
      end

      StXfer: begin
        busy = 1'b1;
        if (gap_q) begin
          // Mandatory idle cycle between an ack and the next request.
          gap_d = 1'b0;
        end else begin
          mem_req  = 1'b1;
          mem_we   = op_q;
          mem_addr = addr_q;
          rf_addr  = is_extra ? '0 : cur_q[RW-1:0];
          lr_sel   = (op_q == OpPush) && is_extra;
          if (mem_ack) begin
            rf_wr  = (op_q == OpPop) && !is_extra;
            pc_wr  = (op_q == OpPop) && is_extra;
            gap_d  = 1'b1;
            addr_d = addr_q + AW'(WB);
            if (scan_valid) begin
              cur_d = scan_idx;
            end else begin
              state_d = StDone;
            end
          end
        end
      end

      StDone: begin
        done  = 1'b1;
        fault = fault_q;
        if (!fault_q) begin
          sp_d = new_sp_q;
        end
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign sp_out = sp_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      sp_q     <= SP_TOP;
      new_sp_q <= '0;
      addr_q   <= '0;
      list_q   <= '0;
      cur_q    <= '0;
      op_q     <= 1'b0;
      fault_q  <= 1'b0;
      gap_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sp_q     <= sp_d;
      new_sp_q <= new_sp_d;
      addr_q   <= addr_d;
      list_q   <= list_d;
      cur_q    <= cur_d;
      op_q     <= op_d;
      fault_q  <= fault_d;
      gap_q    <= gap_d;
    end
  end

endmodule

// File: tb/tb_stack_burst_sequencer.sv
module tb_stack_burst_sequencer;

  localparam int WB = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        op_push = 1'b0;
  logic [7:0]  reg_list = '0;
  logic        extra = 1'b0;
  logic        sp_load = 1'b0;
  logic [15:0] sp_load_val = '0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, lr_sel, rf_wr, pc_wr, busy, done, fault;
  logic [15:0] mem_addr, sp_out;
  logic [2:0]  rf_addr;

  stack_burst_sequencer dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .op_push     (op_push),
    .reg_list    (reg_list),
    .extra       (extra),
    .sp_load     (sp_load),
    .sp_load_val (sp_load_val),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .rf_addr     (rf_addr),
    .lr_sel      (lr_sel),
    .rf_wr       (rf_wr),
    .pc_wr       (pc_wr),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .sp_out      (sp_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    int addr;
    bit we;
    int rf;
    bit lr;
    bit pc;
  } beat_t;

  typedef struct {
    logic [15:0] addr;
    logic [2:0]  rf;
    logic        lr;
    logic        pc;
  } log_t;

  // Reference model: pending beats of the current op plus SP bookkeeping.
  beat_t m_beats[$];
  log_t  log_q[$];
  bit    m_gap = 0;
  bit    m_done_now = 0;
  bit    m_fault = 0;
  int    m_sp = 'hFFFC;
  int    m_new_sp = 0;

  // DMEM responder: ack after a fixed or random number of wait cycles.
  int ack_wait = 1;
  bit ack_rand = 0;
  always @(posedge clk) begin : ack_drv
    int cnt;
    int cur_wait;
    #1;
    if (!mem_req) begin
      cnt = 0;
      mem_ack = 1'b0;
    end else begin
      if (cnt == 0) cur_wait = ack_rand ? int'($urandom_range(0, 3)) : ack_wait;
      mem_ack = (cnt >= cur_wait);
      cnt++;
    end
  end

  // Compare process: check every output against the model each cycle, then advance it.
  always @(negedge clk) begin : cmp
    bit    req_e, idle, done_next;
    beat_t b;
    int    n, off, ns, base, k;
    if (!resetn) begin
      chk("rst_outputs", {mem_req, mem_we, mem_addr, rf_addr, lr_sel, rf_wr, pc_wr,
                          busy, done, fault}, 0);
      chk("rst_sp", sp_out, 32'hFFFC);
      m_beats.delete();
      m_gap = 0;
      m_done_now = 0;
      m_fault = 0;
      m_sp = 'hFFFC;
    end else begin
      req_e = (m_beats.size() > 0) && !m_gap;
      idle  = (m_beats.size() == 0) && !m_done_now;
      chk("sp_out", sp_out, m_sp);
      chk("busy", busy, m_beats.size() > 0);
      chk("done", done, m_done_now);
      chk("fault", fault, m_done_now && m_fault);
      chk("mem_req", mem_req, req_e);
      if (req_e) begin
        b = m_beats[0];
        chk("mem_addr", mem_addr, b.addr);
        chk("mem_we", mem_we, b.we);
        chk("lr_sel", lr_sel, b.lr);
        if (!b.lr && !b.pc) chk("rf_addr", rf_addr, b.rf);
        chk("rf_wr", rf_wr, mem_ack && !b.we && !b.pc);
        chk("pc_wr", pc_wr, mem_ack && b.pc);
      end else begin
        chk("wr_no_beat", {rf_wr, pc_wr}, 0);
      end
      if (mem_req && mem_ack) log_q.push_back('{mem_addr, rf_addr, lr_sel, pc_wr});

      done_next = 0;
      if (m_done_now && !m_fault) m_sp = m_new_sp;
      if (req_e && mem_ack) begin
        void'(m_beats.pop_front());
        m_gap = 1;
        if (m_beats.size() == 0) done_next = 1;
      end else begin
        m_gap = 0;
      end
      if (idle && start) begin
        n   = $countones(reg_list) + int'(extra);
        off = n * WB;
        if (op_push) begin
          ns = m_sp - off;
          m_fault = ns < 'h8000;
          base = ns;
        end else begin
          ns = m_sp + off;
          m_fault = ns > 'hFFFC;
          base = m_sp;
        end
        m_new_sp = ns;
        if (m_fault || n == 0) begin
          done_next = 1;
        end else begin
          k = 0;
          for (int i = 0; i < 8; i++) begin
            if (reg_list[i]) begin
              m_beats.push_back('{base + k * WB, op_push, i, 1'b0, 1'b0});
              k++;
            end
          end
          if (extra) m_beats.push_back('{base + k * WB, op_push, 0, op_push, !op_push});
        end
      end else if (idle && sp_load) begin
        m_sp = int'(sp_load_val);
      end
      m_done_now = done_next;
    end
  end

  logic last_fault;

  task automatic wait_done(string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 300);
    chk({name, "_done_seen"}, done, 1);
    last_fault = fault;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with the DUT in IDLE.
  task automatic do_op(string name, bit push, logic [7:0] list, bit ext, bit ld,
                       logic [15:0] ldv);
    op_push = push;
    reg_list = list;
    extra = ext;
    sp_load = ld;
    sp_load_val = ldv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sp_load = 1'b0;
    // Scramble op inputs: they must only be sampled with start.
    reg_list = 8'($urandom);
    op_push = 1'($urandom);
    extra = 1'($urandom);
    wait_done(name);
  endtask

  task automatic do_load(logic [15:0] v);
    sp_load = 1'b1;
    sp_load_val = v;
    @(posedge clk);
    #1;
    sp_load = 1'b0;
  endtask

  function automatic logic [15:0] pick_sp();
    logic [15:0] r;
    case ($urandom_range(0, 5))
      0: r = 16'hFFFC;
      1: r = 16'h8000;
      2: r = 16'h8010;
      3: r = 16'h8024;
      4: r = 16'hFFE0;
      default: r = 16'($urandom_range(16'h8000, 16'hFFFC)) & 16'hFFFC;
    endcase
    return r;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("init_sp", sp_out, 32'hFFFC);
    chk("init_busy", busy, 0);

    // PUSH {R0,R2,R7}+LR, 1-cycle ack latency.
    log_q.delete();
    ack_wait = 1;
    do_op("push4", 1'b1, 8'b1000_0101, 1'b1, 1'b0, 16'h0);
    chk("push4_nbeats", log_q.size(), 4);
    chk("push4_a0", log_q[0].addr, 32'hFFEC);
    chk("push4_a1", log_q[1].addr, 32'hFFF0);
    chk("push4_a2", log_q[2].addr, 32'hFFF4);
    chk("push4_a3", log_q[3].addr, 32'hFFF8);
    chk("push4_rf", {log_q[0].rf, log_q[1].rf, log_q[2].rf}, {3'd0, 3'd2, 3'd7});
    chk("push4_lr", log_q[3].lr, 1);
    chk("push4_sp", sp_out, 32'hFFEC);

    // POP same list, 3 wait cycles.
    log_q.delete();
    ack_wait = 3;
    do_op("pop4", 1'b0, 8'b1000_0101, 1'b1, 1'b0, 16'h0);
    chk("pop4_nbeats", log_q.size(), 4);
    chk("pop4_a0", log_q[0].addr, 32'hFFEC);
    chk("pop4_a3", log_q[3].addr, 32'hFFF8);
    chk("pop4_pc", {log_q[2].pc, log_q[3].pc}, 2'b01);
    chk("pop4_sp", sp_out, 32'hFFFC);

    // Push overflow.
    do_load(16'h8010);
    chk("load_8010", sp_out, 32'h8010);
    log_q.delete();
    do_op("push_ovf", 1'b1, 8'hFF, 1'b1, 1'b0, 16'h0);
    chk("push_ovf_fault", last_fault, 1);
    chk("push_ovf_nbeats", log_q.size(), 0);
    chk("push_ovf_sp", sp_out, 32'h8010);

    // Pop underflow, then empty list.
    do_load(16'hFFFC);
    do_op("pop_unf", 1'b0, 8'h01, 1'b0, 1'b0, 16'h0);
    chk("pop_unf_fault", last_fault, 1);
    chk("pop_unf_sp", sp_out, 32'hFFFC);
    log_q.delete();
    do_op("empty", 1'b1, 8'h00, 1'b0, 1'b0, 16'h0);
    chk("empty_fault", last_fault, 0);
    chk("empty_nbeats", log_q.size(), 0);
    chk("empty_sp", sp_out, 32'hFFFC);

    // start wins over sp_load in the same cycle.
    ack_wait = 0;
    do_op("start_ld", 1'b1, 8'h03, 1'b0, 1'b1, 16'hA000);
    chk("start_ld_sp", sp_out, 32'hFFF4);
    do_load(16'hA000);
    chk("load_a000", sp_out, 32'hA000);

    // Reset during the third PUSH beat.
    do_load(16'hFFFC);
    log_q.delete();
    ack_wait = 1;
    op_push = 1'b1;
    reg_list = 8'h07;
    extra = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (log_q.size() == 2 && mem_req) break;
      @(posedge clk);
      #1;
    end
    chk("rst_beat3_reached", (log_q.size() == 2) && mem_req, 1);
    resetn = 1'b0;
    #1;
    chk("async_rst_outputs", {mem_req, mem_we, mem_addr, busy, done, fault}, 0);
    chk("async_rst_sp", sp_out, 32'hFFFC);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_sp", sp_out, 32'hFFFC);

    // Randomized traffic.
    ack_rand = 1;
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 6) == 0) begin
        do_load(pick_sp());
      end else begin
        do_op("rand", 1'($urandom),
              ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom),
              1'($urandom), ($urandom_range(0, 9) == 0), pick_sp());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
